// File: rtl/ddd_rat_ctrl.sv
// Delay-chip programming controller: stages a settings word in a shadow register,
// then drives a start/busy handshake with the downstream programmer and retries on failed verify.
module ddd_rat_ctrl #(
    parameter logic [2:0] MXRETRY = 3'd3,
    parameter logic [7:0] TIMEOUT = 8'd255,
    parameter logic [3:0] DEF_OE  = 4'hF,
    parameter logic [3:0] DEF_DLY = 4'h0
) (
    input  logic        clock,
    input  logic        gbl_reset,
    input  logic        wr_en,
    input  logic [19:0] wr_data,
    input  logic        req,
    input  logic        ddd_busy,
    input  logic        ddd_verify_ok,
    output logic        ddd_start,
    output logic [3:0]  oe,
    output logic [3:0]  delay_ch0,
    output logic [3:0]  delay_ch1,
    output logic [3:0]  delay_ch2,
    output logic [3:0]  delay_ch3,
    output logic        done,
    output logic        fail,
    output logic        timeout,
    output logic [2:0]  retry_cnt,
    output logic        ctrl_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_RELEASE,
        S_CHECK
    } state_t;

    localparam logic [19:0] SHADOW_RST = {DEF_DLY, DEF_DLY, DEF_DLY, DEF_DLY, DEF_OE};

    state_t      state_q;
    logic [19:0] shadow_q;
    logic [19:0] shadow_d;
    logic [19:0] active_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        tmo_hit;
    logic        start_q;
    logic        done_q;
    logic        fail_q;
    logic        tmo_q;
    logic [2:0]  retry_q;
    logic        pend_q;
    logic        busy_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // LOAD takes a same-cycle write so the freshest settings reach the chip.
    assign shadow_d = wr_en ? wr_data : shadow_q;
    assign cnt_d    = sat_inc(cnt_q);
    assign tmo_hit  = (cnt_d >= TIMEOUT);

    always_ff @(posedge clock) begin
        if (gbl_reset) begin
            state_q  <= S_IDLE;
            shadow_q <= SHADOW_RST;
            active_q <= SHADOW_RST;
            cnt_q    <= 8'd0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            tmo_q    <= 1'b0;
            retry_q  <= 3'd0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            busy_q   <= (state_q != S_IDLE);
            if (req && (state_q != S_IDLE)) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (req || pend_q) begin
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        tmo_q   <= 1'b0;
                        retry_q <= 3'd0;
                        pend_q  <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    active_q <= shadow_d;
                    state_q  <= S_START;
                end
                S_START: begin
                    start_q <= 1'b1;
                    cnt_q   <= 8'd0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (ddd_busy) begin
                        start_q <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= S_RELEASE;
                    end else if (tmo_hit) begin
                        start_q <= 1'b0;
                        fail_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                        state_q <= S_IDLE;
                    end else begin
                        start_q <= 1'b1;
                        cnt_q   <= cnt_d;
                    end
                end
                S_RELEASE: begin
                    start_q <= 1'b0;
                    if (!ddd_busy) begin
                        state_q <= S_CHECK;
                    end else if (tmo_hit) begin
                        fail_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_CHECK: begin
                    if (ddd_verify_ok) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (retry_q < MXRETRY) begin
                        retry_q <= retry_q + 3'd1;
                        state_q <= S_LOAD;
                    end else begin
                        fail_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ddd_start = start_q;
    assign oe        = active_q[3:0];
    assign delay_ch0 = active_q[7:4];
    assign delay_ch1 = active_q[11:8];
    assign delay_ch2 = active_q[15:12];
    assign delay_ch3 = active_q[19:16];
    assign done      = done_q;
    assign fail      = fail_q;
    assign timeout   = tmo_q;
    assign retry_cnt = retry_q;
    assign ctrl_busy = busy_q;

endmodule

// File: doc/ddd_rat_ctrl.md
DDD_RAT_CTRL -- requirements
Module: ddd_rat_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- MXRETRY, 3, max re-attempts after a failed verify (3 bits).
- TIMEOUT, 255, handshake timeout in clocks (8 bits).
- DEF_OE, 4'hF, reset value of oe.
- DEF_DLY, 4'h0, reset value of every delay channel.

REQ-002 The block SHALL have the following ports (clock and reset first):
- clock  in  1  single clock for all logic.
- gbl_reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the settings word.
- wr_data  in  20  settings: [3:0] oe, [7:4] ch0, [11:8] ch1, [15:12] ch2, [19:16] ch3.
- req  in  1  single-cycle program request.
- ddd_busy  in  1  busy from the downstream delay-chip programmer.
- ddd_verify_ok  in  1  verify result from the downstream programmer.
- ddd_start  out  1  start level to the programmer.
- oe  out  4  active output enables.
- delay_ch0..delay_ch3  out  4 each  active channel delays.
- done  out  1  last cycle verified OK.
- fail  out  1  last cycle failed, by retries exhausted or timeout.
- timeout  out  1  last failure was a timeout.
- retry_cnt  out  3  re-attempts used in the current or last cycle.
- ctrl_busy  out  1  controller not in IDLE.

Function
REQ-003 Shadow register: the block SHALL capture wr_data into a 20-bit shadow on any clock with wr_en=1, regardless of state.
REQ-004 Active outputs: oe and delay_ch* SHALL change only in the LOAD state, copying the shadow, so they stay stable while the programmer shifts data.
REQ-005 State machine: states SHALL be IDLE, LOAD, START, WAIT_BUSY, RELEASE and CHECK; every output SHALL be registered.
REQ-006 IDLE: on req=1, or pending_req=1, the block SHALL clear done, fail, timeout, retry_cnt and pending_req, then go to LOAD.
REQ-007 LOAD: the block SHALL copy shadow to the active outputs and go to START; with wr_en=1 in the same cycle, the newly written value SHALL be copied.
REQ-008 START: the block SHALL set ddd_start=1, clear the timeout counter and go to WAIT_BUSY; ddd_start SHALL first be high 3 clocks after req is sampled in IDLE.
REQ-009 WAIT_BUSY: ddd_start SHALL be held at 1.
- On ddd_busy=1: ddd_start<=0, counter cleared, go to RELEASE.
- On counter reaching TIMEOUT: go to IDLE with ddd_start<=0, fail<=1, timeout<=1.
REQ-010 RELEASE: ddd_start SHALL be held at 0.
- On ddd_busy=0: go to CHECK.
- On counter reaching TIMEOUT: go to IDLE with fail<=1, timeout<=1.
REQ-011 CHECK: the block SHALL sample ddd_verify_ok.
- If 1: done<=1, go to IDLE.
- Else if retry_cnt<MXRETRY: retry_cnt<=retry_cnt+1, go to LOAD.
- Else: fail<=1, go to IDLE.
REQ-012 The timeout counter SHALL increment every clock in WAIT_BUSY and RELEASE and SHALL saturate, never wrap.
REQ-013 A req arriving outside IDLE SHALL set pending_req; multiple such requests SHALL collapse into one.
REQ-014 ctrl_busy SHALL equal (state != IDLE), registered.
REQ-015 done and fail SHALL never both be 1, and SHALL hold their value until the next accepted request or reset.
REQ-016 retry_cnt SHALL never exceed MXRETRY.

Reset
REQ-017 On gbl_reset=1 sampled at a clock edge, the block SHALL drive the following on the next edge, overriding any operation in progress:
- state IDLE.
- ddd_start 0.
- oe and shadow oe field DEF_OE; delay_ch* and shadow delay fields DEF_DLY.
- done, fail, timeout, retry_cnt, pending_req, ctrl_busy and counter all 0.
REQ-018 Reset SHALL take priority over wr_en and req in the same cycle.

Verification
REQ-019 Write 20'hA5C3F, then req; model asserts busy 3 clocks after start and drops it 80 clocks after start falls, with verify_ok=1 -> oe=F, ch0=3, ch1=C, ch2=5, ch3=A; ddd_start high at req+3; done=1, fail=0, retry_cnt=0.
REQ-020 verify_ok=0 on the first two attempts, then 1 -> three start pulses; done=1, retry_cnt=2.
REQ-021 verify_ok stuck 0 with MXRETRY=3 -> four start pulses; fail=1, timeout=0, retry_cnt=3, done=0.
REQ-022 ddd_busy stuck 0 -> ddd_start falls and fail=1, timeout=1 exactly TIMEOUT clocks after entering WAIT_BUSY; ctrl_busy=0 one clock later.
REQ-023 wr_en=1 with 20'h12345 while in RELEASE, and req also pulsed -> outputs unchanged until the pending cycle's LOAD, then oe=5, ch0=4, ch1=3, ch2=2, ch3=1.
REQ-024 gbl_reset asserted in WAIT_BUSY -> next edge: ddd_start=0, oe=F, all delays 0, all flags 0.
